alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/retro16_alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 53 +++++
 rtl/alu_issue.sv | 119 +++++++++++
 tb/tb_alu_issue.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retro16_alu_pkg.sv
// Shared definitions for the retro16 ALU issue block: op encodings,
// FSM states, command entry layout and default queue depth.
package retro16_alu_pkg;

  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned CMD_W              = 39;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } cmd_t;

  // Encodings 001..011 are unassigned and flagged back to the caller.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: power-of-two depth, wrapping pointers, occupancy count
// one bit wider than the pointers so full and empty stay distinct.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  // A push while full is refused even if a pop frees a slot that cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issues queued commands to an external combinational ALU and returns
// tagged results over a valid/ready response channel, in order.
module alu_issue
  import retro16_alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [15:0] alu_operand1,
  output logic [15:0] alu_operand2,
  output logic [2:0]  alu_operation,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_illegal,
  output logic        busy
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  cmd_t          push_cmd, head_cmd;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;
  state_t        state_q, state_d;

  logic [15:0] op1_q, op2_q, rsp_result_q;
  logic [2:0]  opc_q;
  logic [3:0]  tag_q, rsp_tag_q;
  logic        rsp_zero_q, rsp_neg_q, rsp_illegal_q;

  assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = fifo_empty ? S_IDLE : S_EXEC;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == S_RESP);
    fifo_pop  = !fifo_empty &&
                ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op1_q         <= '0;
      op2_q         <= '0;
      opc_q         <= '0;
      tag_q         <= '0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_neg_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      if (fifo_pop) begin
        op1_q <= head_cmd.a;
        op2_q <= head_cmd.b;
        opc_q <= head_cmd.op;
        tag_q <= head_cmd.tag;
      end
      if (state_q == S_EXEC) begin
        rsp_result_q  <= alu_result;
        rsp_tag_q     <= tag_q;
        rsp_zero_q    <= (alu_result == '0);
        rsp_neg_q     <= alu_result[15];
        rsp_illegal_q <= is_illegal_op(opc_q);
      end
    end
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = opc_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_neg       = rsp_neg_q;
  assign rsp_illegal   = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU attached to the ALU port, directed
// scenarios plus a randomized run against an in-order expectation queue.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [15:0] alu_operand1, alu_operand2, alu_result;
  logic [2:0]  alu_operation;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_zero, rsp_neg, rsp_illegal, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  // SHIFT treats b as signed: positive shifts left, negative shifts right (logical).
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    int sh;
    alu_ref = '0;
    case (op)
      3'b000: begin
        sh = int'($signed(b));
        if (sh >= 16 || sh <= -16) alu_ref = '0;
        else if (sh >= 0)          alu_ref = a << sh;
        else                       alu_ref = a >> (-sh);
      end
      3'b100:  alu_ref = a + b;
      3'b101:  alu_ref = a & b;
      3'b110:  alu_ref = a | b;
      3'b111:  alu_ref = ~a;
      default: alu_ref = '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_operation, alu_operand1, alu_operand2);

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [3:0]  tag;
  } exp_cmd_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL reset_hs: valid/ready/busy=%b expected 010", {rsp_valid, cmd_ready, busy});
    end
    tests++;
    if ({alu_operand1, alu_operand2, alu_operation} !== 35'd0) begin
      fails++;
      $display("FAIL reset_alu: got %h %h %h expected zeros", alu_operand1, alu_operand2, alu_operation);
    end
    tests++;
    if ({rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal} !== 23'd0) begin
      fails++;
      $display("FAIL reset_rsp: got %h tag %h z%b n%b i%b expected zeros",
               rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal);
    end
  endtask

  task automatic test_add_latency();
    int n;
    issue(3'b100, 16'h7FFF, 16'h0001, 4'd3);
    wait_valid(n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL add_latency: rsp_valid in cycle %0d expected cycle 3", n + 1);
    end
    tests++;
    if ({rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal} !== {16'h8000, 4'd3, 3'b010}) begin
      fails++;
      $display("FAIL add_rsp: got %h tag %0d z%b n%b i%b expected 8000 tag 3 z0 n1 i0",
               rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal);
    end
    tick();
    tick();
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL add_idle: valid/busy=%b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_shift();
    int n;
    issue(3'b000, 16'h0001, 16'h0004, 4'd5);
    wait_valid(n);
    tests++;
    if (!rsp_valid || rsp_result !== 16'h0010 || rsp_tag !== 4'd5) begin
      fails++;
      $display("FAIL shift_left: valid %b result %h tag %0d expected 1 0010 5", rsp_valid, rsp_result, rsp_tag);
    end
    tick();
    issue(3'b000, 16'h8000, 16'hFFFF, 4'd6);
    wait_valid(n);
    tests++;
    if (!rsp_valid || rsp_result !== 16'h4000 || rsp_neg !== 1'b0) begin
      fails++;
      $display("FAIL shift_right: valid %b result %h neg %b expected 1 4000 0", rsp_valid, rsp_result, rsp_neg);
    end
    tick();
  endtask

  task automatic test_illegal();
    int n;
    issue(3'b010, 16'h1234, 16'h0001, 4'd9);
    wait_valid(n);
    tests++;
    if (!rsp_valid || {rsp_result, rsp_zero, rsp_neg, rsp_illegal} !== {16'h0000, 3'b101}) begin
      fails++;
      $display("FAIL illegal_op: valid %b result %h z%b n%b i%b expected 1 0000 z1 n0 i1",
               rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_illegal);
    end
    tests++;
    if (alu_operation !== 3'b010) begin
      fails++;
      $display("FAIL illegal_passthru: alu_operation %b expected 010", alu_operation);
    end
    tick();
  endtask

  task automatic test_full_order();
    exp_cmd_t sent[5];
    int got_tag[$];
    int got_cyc[$];
    logic [15:0] exp_r;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sent[i].op = 3'($urandom_range(4, 7)); sent[i].a = 16'($urandom); sent[i].b = 16'($urandom);
      sent[i].tag = 4'(i);
      tests++;
      if (cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL full_accept%0d: cmd_ready %b expected 1", i, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = sent[i].op; cmd_a = sent[i].a; cmd_b = sent[i].b; cmd_tag = sent[i].tag;
      tick();
    end
    cmd_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL full_stall%0d: cmd_ready %b expected 0", i, cmd_ready);
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) begin
        exp_r = alu_ref(sent[got_tag.size() % 5].op, sent[got_tag.size() % 5].a, sent[got_tag.size() % 5].b);
        tests++;
        if (rsp_result !== exp_r) begin
          fails++;
          $display("FAIL order_result%0d: got %h expected %h", got_tag.size(), rsp_result, exp_r);
        end
        got_tag.push_back(int'(rsp_tag));
        got_cyc.push_back(c);
      end
      tick();
    end
    tests++;
    if (got_tag.size() !== 5) begin
      fails++;
      $display("FAIL order_count: got %0d responses expected 5", got_tag.size());
    end
    for (int i = 0; i < got_tag.size() && i < 5; i++) begin
      tests++;
      if (got_tag[i] !== i) begin
        fails++;
        $display("FAIL order_tag%0d: got %0d expected %0d", i, got_tag[i], i);
      end
      if (i > 0) begin
        tests++;
        if (got_cyc[i] - got_cyc[i-1] !== 2) begin
          fails++;
          $display("FAIL throughput%0d: gap %0d expected 2", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] s_res, s_op1;
    logic [3:0]  s_tag;
    logic [2:0]  s_flags;
    rsp_ready = 1'b0;
    issue(3'b110, 16'h0F00, 16'h00F0, 4'd11);
    issue(3'b101, 16'hFFFF, 16'h1234, 4'd12);
    wait_valid(n);
    s_res = rsp_result; s_tag = rsp_tag; s_flags = {rsp_zero, rsp_neg, rsp_illegal}; s_op1 = alu_operand1;
    tests++;
    if (!rsp_valid || s_res !== 16'h0FF0 || s_tag !== 4'd11) begin
      fails++;
      $display("FAIL bp_first: valid %b result %h tag %0d expected 1 0ff0 11", rsp_valid, s_res, s_tag);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (!rsp_valid || rsp_result !== s_res || rsp_tag !== s_tag ||
          {rsp_zero, rsp_neg, rsp_illegal} !== s_flags || alu_operand1 !== s_op1 || !busy) begin
        fails++;
        $display("FAIL bp_hold%0d: valid %b result %h tag %0d op1 %h busy %b changed under backpressure",
                 i, rsp_valid, rsp_result, rsp_tag, alu_operand1, busy);
      end
    end
    rsp_ready = 1'b1;
    tick();
    wait_valid(n);
    tests++;
    if (!rsp_valid || rsp_result !== 16'h1234 || rsp_tag !== 4'd12) begin
      fails++;
      $display("FAIL bp_second: valid %b result %h tag %0d expected 1 1234 12", rsp_valid, rsp_result, rsp_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stale;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 16'(i); cmd_b = 16'd1; cmd_tag = 4'(i);
      if (i == 4) rsp_ready = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tests++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b011) begin
      fails++;
      $display("FAIL midrst_pre: valid/busy/ready=%b expected 011", {rsp_valid, busy, cmd_ready});
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      fails++;
      $display("FAIL midrst_post: valid/busy/ready=%b expected 001", {rsp_valid, busy, cmd_ready});
    end
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || busy) stale++;
      tick();
    end
    tests++;
    if (stale !== 0) begin
      fails++;
      $display("FAIL midrst_stale: %0d cycles with activity expected 0", stale);
    end
  endtask

  task automatic test_random();
    exp_cmd_t q[$];
    exp_cmd_t e, c;
    logic [15:0] er;
    logic        held;
    logic [22:0] held_val;
    int          drain;
    held = 1'b0;
    held_val = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc < 400) begin
        cmd_valid = ($urandom_range(0, 1) == 1);
        cmd_op = 3'($urandom);
        cmd_a = 16'($urandom);
        cmd_b = ($urandom_range(0, 1) == 1) ? 16'($signed(5'($urandom))) : 16'($urandom);
        cmd_tag = 4'($urandom);
        rsp_ready = ($urandom_range(0, 9) < 7);
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        tests++;
        if (!rsp_valid || {rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal} !== held_val) begin
          fails++;
          $display("FAIL rand_hold@%0d: valid %b result %h tag %0d not held", cyc, rsp_valid, rsp_result, rsp_tag);
        end
      end
      if (cmd_valid && cmd_ready) begin
        c.op = cmd_op; c.a = cmd_a; c.b = cmd_b; c.tag = cmd_tag;
        q.push_back(c);
      end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_spurious@%0d: response tag %0d with nothing outstanding", cyc, rsp_tag);
        end else begin
          e = q.pop_front();
          er = alu_ref(e.op, e.a, e.b);
          if ({rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal} !==
              {er, e.tag, er == 16'h0, er[15], e.op inside {3'b001, 3'b010, 3'b011}}) begin
            fails++;
            $display("FAIL rand_rsp@%0d: got %h tag %0d z%b n%b i%b expected %h tag %0d (op %b a %h b %h)",
                     cyc, rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal, er, e.tag, e.op, e.a, e.b);
          end
        end
      end
      held = rsp_valid && !rsp_ready;
      held_val = {rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal};
      @(posedge clk);
      #1;
    end
    drain = q.size();
    tests++;
    if (drain !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rand_drain: %0d responses missing, busy %b expected 0 and 0", drain, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_shift();
    test_illegal();
    test_full_order();
    test_backpressure();
    test_reset_mid();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
